// File: rtl/memory_instruc_loader_if.sv
// Loader/fetch bus of the IF-stage instruction memory.
// The slave modport is the memory side; the master modport drives loads and fetches.
interface memory_instruc_loader_if #(
  parameter int SIZE_ADDR_PC = 32,
  parameter int WORD_WIDTH   = 32,
  parameter int DEPTH        = 256
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                    i_load_start;
  logic                    i_load_valid;
  logic [7:0]              i_load_byte;
  logic                    i_load_done;
  logic                    o_load_ready;
  logic [CW-1:0]           o_load_count;
  logic                    i_step;
  logic [SIZE_ADDR_PC-1:0] i_pc;
  logic [WORD_WIDTH-1:0]   o_instruction;
  logic                    o_pc_invalid;
  logic                    o_halt;
  logic [1:0]              o_state;

  modport slave (
    input  i_load_start, i_load_valid, i_load_byte, i_load_done, i_step, i_pc,
    output o_load_ready, o_load_count, o_instruction, o_pc_invalid, o_halt, o_state
  );

  modport master (
    output i_load_start, i_load_valid, i_load_byte, i_load_done, i_step, i_pc,
    input  o_load_ready, o_load_count, o_instruction, o_pc_invalid, o_halt, o_state
  );
endinterface

// File: rtl/memory_instruc_loader.sv
// Instruction memory for the IF stage: a byte-serial big-endian loader fills the RAM,
// then registered fetches gated by i_step return words with PC-valid and HALT flags.
module memory_instruc_loader #(
  parameter int                    SIZE_ADDR_PC = 32,
  parameter int                    WORD_WIDTH   = 32,
  parameter int                    DEPTH        = 256,
  parameter logic [WORD_WIDTH-1:0] HALT_WORD    = 32'hFFFFFFFF
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  memory_instruc_loader_if.slave   bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int BYTES = WORD_WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LOADING = 2'b01,
    READY   = 2'b10
  } state_t;

  state_t                state_q, state_d;
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [WORD_WIDTH-1:0] asm_q, asm_d;
  logic                  fetch_ok_q, fetch_ok_d;
  logic                  pc_inv_q, pc_inv_d;

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [WORD_WIDTH-1:0] rd_data_q;

  logic                  load_ready;
  logic                  accept;
  logic [WORD_WIDTH-1:0] asm_shift;
  logic [AW-1:0]         rd_idx;
  logic                  fetch_bad;
  logic                  wr_en;
  logic                  rd_en;

  assign load_ready = (state_q == LOADING) && (wr_ptr_q < (AW+1)'(DEPTH));
  assign accept     = load_ready && bus.i_load_valid;
  assign asm_shift  = (asm_q << 8) | WORD_WIDTH'(bus.i_load_byte);
  assign rd_idx     = bus.i_pc[AW+1:2];
  // Words beyond the loaded count are stale from an earlier program, so they are invalid too.
  assign fetch_bad  = (bus.i_pc[1:0] != 2'b00)
                   || ({1'b0, rd_idx} >= wr_ptr_q)
                   || (bus.i_pc >= SIZE_ADDR_PC'(DEPTH * 4));

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    fetch_ok_d = fetch_ok_q;
    pc_inv_d   = pc_inv_q;
    wr_en      = 1'b0;
    rd_en      = 1'b0;

    if (bus.i_load_start) begin
      state_d    = LOADING;
      wr_ptr_d   = '0;
      byte_cnt_d = '0;
      asm_d      = '0;
      fetch_ok_d = 1'b0;
      pc_inv_d   = 1'b0;
    end else begin
      case (state_q)
        LOADING: begin
          if (accept) begin
            asm_d = asm_shift;
            if (byte_cnt_q == BCW'(BYTES - 1)) begin
              wr_en      = 1'b1;
              wr_ptr_d   = wr_ptr_q + 1'b1;
              byte_cnt_d = '0;
              if (wr_ptr_q == (AW+1)'(DEPTH - 1)) state_d = READY;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end
          // Done after the byte is taken: a completed word is kept, a partial one dropped.
          if (bus.i_load_done) begin
            state_d    = READY;
            byte_cnt_d = '0;
          end
        end
        READY: begin
          if (bus.i_step) begin
            rd_en      = !fetch_bad;
            fetch_ok_d = !fetch_bad;
            pc_inv_d   = fetch_bad;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      fetch_ok_q <= 1'b0;
      pc_inv_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      fetch_ok_q <= fetch_ok_d;
      pc_inv_q   <= pc_inv_d;
    end
  end

  // RAM port kept reset-free; fetch_ok_q masks the read register after reset or reload.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= asm_shift;
    if (rd_en) rd_data_q <= mem[rd_idx];
  end

  assign bus.o_load_ready  = load_ready;
  assign bus.o_load_count  = wr_ptr_q;
  assign bus.o_instruction = fetch_ok_q ? rd_data_q : '0;
  assign bus.o_pc_invalid  = pc_inv_q;
  assign bus.o_halt        = fetch_ok_q && (rd_data_q == HALT_WORD);
  assign bus.o_state       = state_q;
endmodule
